// File: rtl/core_dbg_pkg.sv
// core_dbg_pkg: shared types and register map constants for the core debug controller
package core_dbg_pkg;
    typedef enum logic [1:0] {RUN, HALTED, STEP} dbg_state_e;
    localparam int REG_CTRL     = 0;
    localparam int REG_STATUS   = 1;
    localparam int REG_PC       = 2;
    localparam int REG_SCRATCH0 = 3;
    localparam int CTRL_HALT    = 0;
    localparam int CTRL_RESUME  = 1;
    localparam int CTRL_STEP    = 2;
    localparam int CTRL_ERR_CLR = 3;
    localparam int STAT_HALTED   = 0;
    localparam int STAT_RUNNING  = 1;
    localparam int STAT_STEPPING = 2;
    localparam int STAT_ERR      = 3;
    localparam int STAT_CNT_LSB  = 8;
    localparam int ERR_CNT_MAX   = 255;
endpackage

// File: rtl/core_dbg_run_fsm.sv
// core_dbg_run_fsm: halt/resume/single-step run control with registered core outputs
module core_dbg_run_fsm
    import core_dbg_pkg::*;
#(
    parameter int HALT_ON_RESET = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       halt_i,
    input  logic       resume_i,
    input  logic       step_i,
    input  logic       core_retire_i,
    output dbg_state_e state_o,
    output logic       core_halt_o,
    output logic       core_step_o
);
    dbg_state_e state_q;
    assign state_o = state_q;
    // a CTRL write in STEP overrides a coincident retire; halt and retire agree anyway
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= (HALT_ON_RESET != 0) ? HALTED : RUN;
            core_halt_o <= (HALT_ON_RESET != 0);
            core_step_o <= 1'b0;
        end else begin
            core_step_o <= 1'b0;
            unique case (state_q)
                RUN: if (halt_i) begin
                    state_q     <= HALTED;
                    core_halt_o <= 1'b1;
                end
                HALTED: if (!halt_i) begin
                    if (step_i) begin
                        state_q     <= STEP;
                        core_halt_o <= 1'b0;
                        core_step_o <= 1'b1;
                    end else if (resume_i) begin
                        state_q     <= RUN;
                        core_halt_o <= 1'b0;
                    end
                end
                STEP: if (halt_i || (!resume_i && core_retire_i)) begin
                    state_q     <= HALTED;
                    core_halt_o <= 1'b1;
                end else if (resume_i) begin
                    state_q     <= RUN;
                    core_halt_o <= 1'b0;
                end
                default: begin
                    state_q     <= RUN;
                    core_halt_o <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: rtl/core_dbg_ctrl.sv
// core_dbg_ctrl: debug register bank with byte strobes, error tracking and run control
module core_dbg_ctrl
    import core_dbg_pkg::*;
#(
    parameter int ADDR_WIDTH    = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_REGS      = 32,
    parameter int HALT_ON_RESET = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    dbg_req,
    input  logic                    dbg_wr_rd,
    input  logic [ADDR_WIDTH-1:0]   dbg_addr,
    input  logic [DATA_WIDTH-1:0]   dbg_wdata,
    input  logic [DATA_WIDTH/8-1:0] dbg_wstrobe,
    output logic [DATA_WIDTH-1:0]   dbg_rdata,
    output logic                    dbg_rd_ready,
    input  logic [DATA_WIDTH-1:0]   core_pc,
    input  logic                    core_retire,
    output logic                    core_halt,
    output logic                    core_step
);
    localparam int NB = DATA_WIDTH / 8;
    logic [DATA_WIDTH-1:0] regs_q [REG_SCRATCH0:NUM_REGS-1];
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d, status;
    logic                  rd_ready_q, err_q;
    logic [7:0]            err_cnt_q, err_cnt_d;
    logic                  rd_req, wr_req, oor, ctrl_wr;
    dbg_state_e            state;
    assign rd_req  = dbg_req && !dbg_wr_rd;
    assign wr_req  = dbg_req && dbg_wr_rd;
    assign oor     = {1'b0, dbg_addr} >= (ADDR_WIDTH+1)'(NUM_REGS);
    assign ctrl_wr = wr_req && dbg_addr == ADDR_WIDTH'(REG_CTRL) && dbg_wstrobe[0];
    assign err_cnt_d = (err_cnt_q == 8'(ERR_CNT_MAX)) ? err_cnt_q : err_cnt_q + 8'd1;
    always_comb begin
        status = '0;
        status[STAT_HALTED] = state == HALTED;
        status[STAT_RUNNING] = state == RUN;
        status[STAT_STEPPING] = state == STEP;
        status[STAT_ERR] = err_q;
        status[STAT_CNT_LSB +: 8] = err_cnt_q;
    end
    // CTRL and out-of-range addresses match no branch and read back as zero
    always_comb begin
        rdata_d = '0;
        if (dbg_addr == ADDR_WIDTH'(REG_STATUS)) rdata_d = status;
        if (dbg_addr == ADDR_WIDTH'(REG_PC)) rdata_d = core_pc;
        for (int i = REG_SCRATCH0; i < NUM_REGS; i++)
            if (dbg_addr == ADDR_WIDTH'(i)) rdata_d = regs_q[i];
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = REG_SCRATCH0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (wr_req) begin
            for (int i = REG_SCRATCH0; i < NUM_REGS; i++)
                for (int b = 0; b < NB; b++)
                    if (dbg_addr == ADDR_WIDTH'(i) && dbg_wstrobe[b])
                        regs_q[i][8*b +: 8] <= dbg_wdata[8*b +: 8];
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else if (dbg_req && oor) begin
            err_q     <= 1'b1;
            err_cnt_q <= err_cnt_d;
        end else if (ctrl_wr && dbg_wdata[CTRL_ERR_CLR]) begin
            err_q     <= 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q    <= '0;
            rd_ready_q <= 1'b0;
        end else begin
            rd_ready_q <= rd_req;
            if (rd_req) rdata_q <= rdata_d;
        end
    end
    assign dbg_rdata    = rdata_q;
    assign dbg_rd_ready = rd_ready_q;
    core_dbg_run_fsm #(.HALT_ON_RESET(HALT_ON_RESET)) u_fsm (
        .clk          (clk),
        .rst_n        (rst_n),
        .halt_i       (ctrl_wr && dbg_wdata[CTRL_HALT]),
        .resume_i     (ctrl_wr && dbg_wdata[CTRL_RESUME]),
        .step_i       (ctrl_wr && dbg_wdata[CTRL_STEP]),
        .core_retire_i(core_retire),
        .state_o      (state),
        .core_halt_o  (core_halt),
        .core_step_o  (core_step)
    );
endmodule

// File: tb/tb_core_dbg_ctrl.sv
// tb_core_dbg_ctrl: directed bench checking two configurations against a behavioural model
module tb_core_dbg_ctrl;
    logic        clk = 1'b0, rst_n = 1'b0, req = 1'b0, wr = 1'b0, retire = 1'b0;
    logic [4:0]  addr = '0;
    logic [31:0] wdata = '0, pc = '0;
    logic [3:0]  strb = '0;
    logic [31:0] rdata [2];
    logic        rdy [2], halt [2], step [2];
    int          errs = 0, checks = 0;
    bit          chk_en = 1'b0;
    always #5 clk = ~clk;
    core_dbg_ctrl #(.NUM_REGS(16), .HALT_ON_RESET(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .dbg_req(req), .dbg_wr_rd(wr), .dbg_addr(addr),
        .dbg_wdata(wdata), .dbg_wstrobe(strb), .dbg_rdata(rdata[0]), .dbg_rd_ready(rdy[0]),
        .core_pc(pc), .core_retire(retire), .core_halt(halt[0]), .core_step(step[0])
    );
    core_dbg_ctrl #(.NUM_REGS(32), .HALT_ON_RESET(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .dbg_req(req), .dbg_wr_rd(wr), .dbg_addr(addr),
        .dbg_wdata(wdata), .dbg_wstrobe(strb), .dbg_rdata(rdata[1]), .dbg_rd_ready(rdy[1]),
        .core_pc(pc), .core_retire(retire), .core_halt(halt[1]), .core_step(step[1])
    );
    // model: st 0=running 1=halted 2=stepping
    int          nr [2] = '{16, 32};
    int          hor [2] = '{0, 1};
    int          st [2], m_cnt [2];
    logic [31:0] m_rd [2];
    logic        m_rdy [2], m_step [2], m_err [2];
    logic [31:0] m_reg [2][32];
    task automatic model_step();
        logic h, r, s, cw;
        logic [31:0] v;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                st[k] = hor[k]; m_rd[k] = 0; m_rdy[k] = 0; m_step[k] = 0; m_err[k] = 0; m_cnt[k] = 0;
                for (int j = 0; j < 32; j++) m_reg[k][j] = 0;
            end else begin
                m_rdy[k] = req && !wr;
                m_step[k] = 0;
                if (req && !wr) begin
                    v = 0;
                    if (int'(addr) < nr[k]) begin
                        if (addr == 1) v = {16'h0, 8'(m_cnt[k]), 4'h0, m_err[k], st[k] == 2, st[k] == 0, st[k] == 1};
                        else if (addr == 2) v = pc;
                        else if (addr >= 3) v = m_reg[k][addr];
                    end
                    m_rd[k] = v;
                end
                if (req && wr && addr >= 3 && int'(addr) < nr[k])
                    for (int b = 0; b < 4; b++) if (strb[b]) m_reg[k][addr][8*b +: 8] = wdata[8*b +: 8];
                cw = req && wr && addr == 0 && strb[0];
                h = cw && wdata[0]; r = cw && wdata[1]; s = cw && wdata[2];
                if (req && int'(addr) >= nr[k]) begin
                    m_err[k] = 1;
                    if (m_cnt[k] < 255) m_cnt[k]++;
                end else if (cw && wdata[3]) m_err[k] = 0;
                if (st[k] == 0) begin
                    if (h) st[k] = 1;
                end else if (st[k] == 1) begin
                    if (!h && s) begin st[k] = 2; m_step[k] = 1; end
                    else if (!h && r) st[k] = 0;
                end else begin
                    if (h) st[k] = 1;
                    else if (r) st[k] = 0;
                    else if (retire) st[k] = 1;
                end
            end
        end
    endtask
    always @(posedge clk) model_step();
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    always @(negedge clk) if (chk_en) for (int k = 0; k < 2; k++) begin
        check($sformatf("dut%0d rd_ready", k), 32'(rdy[k]), 32'(m_rdy[k]));
        check($sformatf("dut%0d rdata", k), rdata[k], m_rd[k]);
        check($sformatf("dut%0d core_halt", k), 32'(halt[k]), 32'(st[k] == 1));
        check($sformatf("dut%0d core_step", k), 32'(step[k]), 32'(m_step[k]));
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic wrt(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        req = 1; wr = 1; addr = a; wdata = d; strb = s;
        tick();
        req = 0; wr = 0;
    endtask
    task automatic rd(input logic [4:0] a);
        req = 1; wr = 0; addr = a;
        tick();
        req = 0;
    endtask
    initial begin
        repeat (2) tick();
        check("reset rdata", rdata[0], 32'h0);
        check("reset rd_ready", 32'(rdy[0]), 32'h0);
        check("reset halt hor0", 32'(halt[0]), 32'h0);
        check("reset halt hor1", 32'(halt[1]), 32'h1);
        check("reset step", 32'(step[0]), 32'h0);
        chk_en = 1;
        rst_n = 1;
        tick();
        wrt(5, 32'hA5A5A5A5, 4'hF);
        wrt(5, 32'h11223344, 4'h5);
        rd(5);
        check("strobe merge", rdata[0], 32'hA522A544);
        check("read ready", 32'(rdy[0]), 32'h1);
        tick();
        check("ready one pulse", 32'(rdy[0]), 32'h0);
        check("rdata hold", rdata[0], 32'hA522A544);
        pc = 32'h1000; req = 1; wr = 0; addr = 2;
        tick();
        check("pc read 1", rdata[0], 32'h1000);
        pc = 32'h1004;
        tick();
        check("pc read 2", rdata[0], 32'h1004);
        check("pc b2b ready", 32'(rdy[0]), 32'h1);
        req = 0;
        tick();
        wrt(0, 32'h1, 4'h1);
        check("halt", 32'(halt[0]), 32'h1);
        rd(1);
        check("status halted", rdata[0], 32'h1);
        wrt(0, 32'h4, 4'h1);
        check("step pulse", 32'(step[0]), 32'h1);
        check("step unhalt", 32'(halt[0]), 32'h0);
        tick();
        check("step single", 32'(step[0]), 32'h0);
        retire = 1;
        tick();
        retire = 0;
        check("retire halts", 32'(halt[0]), 32'h1);
        rd(1);
        check("status after step", rdata[0], 32'h1);
        wrt(0, 32'h2, 4'h1);
        check("resume", 32'(halt[0]), 32'h0);
        wrt(0, 32'h3, 4'h1);
        check("halt beats resume", 32'(halt[0]), 32'h1);
        wrt(0, 32'h2, 4'h1);
        wrt(0, 32'h1, 4'h0);
        check("ctrl needs strobe0", 32'(halt[0]), 32'h0);
        wrt(1, 32'hFFFFFFFF, 4'hF);
        wrt(2, 32'hFFFFFFFF, 4'hF);
        repeat (3) begin
            rd(20);
            check("oor read", rdata[0], 32'h0);
        end
        rd(1);
        check("status err", rdata[0], 32'h030A);
        wrt(0, 32'h8, 4'h1);
        rd(1);
        check("err clear", rdata[0], 32'h0302);
        wrt(20, 32'hDEADBEEF, 4'hF);
        rd(20);
        check("oor write ignored", rdata[0], 32'h0);
        check("scratch 20 dut1", rdata[1], 32'hDEADBEEF);
        repeat (260) rd(31);
        rd(1);
        check("err_cnt saturates", rdata[0], 32'hFF0A);
        wrt(0, 32'h1, 4'h1);
        wrt(0, 32'h4, 4'h1);
        check("step before reset", 32'(step[0]), 32'h1);
        tick();
        rst_n = 0;
        tick();
        rst_n = 1;
        check("reset mid step hor0", 32'(halt[0]), 32'h0);
        check("reset mid step hor1", 32'(halt[1]), 32'h1);
        check("reset no step", 32'(step[0] | step[1]), 32'h0);
        rd(5);
        check("scratch cleared", rdata[0], 32'h0);
        rd(1);
        check("status after reset", rdata[0], 32'h2);
        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/core_dbg_ctrl.md
Name: core_dbg_ctrl

Overview:
- Parametrised debug register bank and run-control unit on the core side of the debug APB slave.
- Consumes the single-cycle request interface (req, wr_rd, addr, wdata) and returns read data with a ready pulse.
- Adds byte strobes, read-only status/PC registers, out-of-range error tracking and a halt/resume/single-step FSM that drives the core pipeline.
- Instantiated inside the core next to fetch.

Parameters:
ADDR_WIDTH, 5, debug register address width
DATA_WIDTH, 32, register width; multiple of 8
NUM_REGS, 32, implemented registers; 4 <= NUM_REGS <= 2**ADDR_WIDTH
HALT_ON_RESET, 0, 1 = FSM leaves reset in HALTED, 0 = RUN

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
dbg_req  in  1  one-cycle request strobe
dbg_wr_rd  in  1  1 = write, 0 = read
dbg_addr  in  ADDR_WIDTH  register index
dbg_wdata  in  DATA_WIDTH  write data
dbg_wstrobe  in  DATA_WIDTH/8  byte enables for writes
dbg_rdata  out  DATA_WIDTH  read data, valid while dbg_rd_ready=1
dbg_rd_ready  out  1  one-cycle read-complete pulse
core_pc  in  DATA_WIDTH  current core PC
core_retire  in  1  instruction-retired pulse
core_halt  out  1  stall core pipeline
core_step  out  1  one-cycle pulse starting a single step

Behaviour:
- Interface decisions:
  - One clock, clk.
  - Reset is synchronous and active-low on rst_n.
  - All state updates happen on posedge clk.
- Reset values:
  - dbg_rdata=0, dbg_rd_ready=0, core_step=0.
  - Scratch registers=0, err_cnt=0.
  - FSM=HALTED with core_halt=1 if HALT_ON_RESET, else RUN with core_halt=0.
  - Reset mid-step aborts the step with no pulse.
- Register map:
  - 0 CTRL: write-only pulse bits: [0] halt, [1] resume, [2] step. Reads return 0.
  - 1 STATUS: read-only: [0] halted, [1] running, [2] stepping, [3] err sticky, [15:8] err_cnt.
  - 2 PC: read-only, returns core_pc sampled in the request cycle.
  - 3..NUM_REGS-1: scratch read/write registers.
- Reads:
  - Request in cycle N gives dbg_rd_ready=1 and dbg_rdata in cycle N+1 (latency 1).
  - dbg_rdata holds its value afterwards.
  - Back-to-back reads every cycle are supported, with one pulse per request.
- Writes:
  - Scratch registers are updated per byte where the dbg_wstrobe bit is 1.
  - Writes to STATUS or PC are ignored silently.
  - Writes never raise dbg_rd_ready.
  - CTRL bits are acted on only if the corresponding strobe byte 0 is set.
- Out-of-range (addr >= NUM_REGS):
  - Write is ignored.
  - Read returns 0 with a normal ready pulse.
  - Both set err sticky and increment err_cnt, which saturates at 255.
  - Err sticky is cleared by writing CTRL bit [3]=1.
- FSM states RUN, HALTED, STEP:
  - RUN: core_halt=0. Halt goes to HALTED, with core_halt=1 from the next cycle. Step and resume are ignored.
  - HALTED: core_halt=1.
    - Resume goes to RUN.
    - Step goes to STEP: core_step pulses 1 cycle and core_halt=0 from the next cycle.
  - STEP: core_halt=0.
    - core_retire=1 goes to HALTED, with core_halt=1 the next cycle.
    - Halt goes to HALTED immediately, with no further retire needed.
    - Resume goes to RUN.
  - Priority when several CTRL bits are written together: halt > step > resume.
  - A CTRL write in the same cycle as core_retire in STEP: the CTRL write wins.
- STATUS reflects the FSM state registered before the read cycle.

Decomposition:
- Package core_dbg_pkg holds:
  - dbg_state_e enum (RUN, HALTED, STEP).
  - Register index constants (REG_CTRL=0, REG_STATUS=1, REG_PC=2, REG_SCRATCH0=3).
  - CTRL and STATUS bit positions.
  - ERR_CNT_MAX=255.
- One sub-module, core_dbg_run_fsm: takes halt/resume/step pulses and core_retire, and produces state, core_halt and core_step.
- The register file, strobe merge and error logic stay in core_dbg_ctrl.

Test Plan:
- Write addr 5 = 0xA5A5A5A5 with wstrobe 4'b1111, then with wstrobe 4'b0101 write 0x11223344, then read addr 5 -> rdata 0xA522A544, rd_ready pulse 1 cycle after req.
- Read addr 2 with core_pc=0x00001000, then read addr 2 again with core_pc=0x00001004 -> rdata 0x1000 then 0x1004 on consecutive ready pulses.
- Write CTRL=0x1 -> core_halt=1 next cycle, STATUS reads 0x1. Write CTRL=0x4 -> core_step pulse, core_halt=0. Pulse core_retire -> core_halt=1, STATUS reads 0x1.
- Write CTRL=0x3 (halt+resume) while in RUN -> state HALTED, core_halt=1.
- With NUM_REGS=16, read addr 20 three times -> rdata 0 each time, STATUS=0x0308|running bit (err_cnt=3, err bit set). Write CTRL=0x8 -> err bit clears, err_cnt stays 3.
- Assert rst_n=0 for 1 cycle during STEP -> state RUN (HALT_ON_RESET=0), core_halt=0, scratch=0, no core_step pulse. Repeat with HALT_ON_RESET=1 -> core_halt=1.
